multi_ch_climate_ctrl: RTL and testbench

//   N-channel threshold controller for the cold-storage unit.
//   - Compares each sensor channel against per-channel HI/LO limits, with hysteresis.
//   - Drives one actuator per channel. Each channel runs in auto or manual-override mode.
//   - Accepts validated threshold/override commands from the UART parser.
//   - Rotates a 16x2 LCD status page through the channels, one channel per tick.

---
 rtl/multi_ch_climate_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_multi_ch_climate_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_climate_ctrl.sv
// multi_ch_climate_ctrl
//   N-channel threshold controller for the cold-storage unit. Each channel
//   drives one actuator from HI/LO limits with hysteresis, or holds a manual
//   override. Commands arrive already framed from the UART parser. A 16x2 LCD
//   status page rotates through the channels, one channel per tick.
//   Optional feature: define CSC_ALARM_LATCH_EN to make the alarm sticky until
//   a 'C' command (or reset) clears it; otherwise it is recomputed every tick.
module multi_ch_climate_ctrl #(
  parameter int                NUM_CH   = 2,
  parameter int                DATA_W   = 8,
  parameter int                TICK_DIV = 50_000_000,
  parameter int                HYST     = 2,
  parameter logic [NUM_CH-1:0] CH_POL   = NUM_CH'(2'b01),
  parameter int                HI_RST   = 18,
  parameter int                LO_RST   = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_CH*DATA_W-1:0] sensor_data_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [7:0]               cmd_code_i,
  input  logic [7:0]               cmd_ch_i,
  input  logic [7:0]               cmd_d1_i,
  input  logic [7:0]               cmd_d0_i,
  output logic                     cmd_ack_o,
  output logic                     cmd_err_o,
  output logic [NUM_CH-1:0]        act_on_o,
  output logic                     alarm_o,
  output logic                     lcd_en_o,
  output logic [127:0]             lcd_row1_o,
  output logic [127:0]             lcd_row2_o
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LIM_W  = 7;           // limits are two decimal digits, 0..99
  localparam int VW     = DATA_W + 2;  // headroom so v+HYST never overflows

  localparam logic [127:0] ROW1_RST = "  Cold Storage  ";
  localparam logic [127:0] ROW2_RST = "     Welcome    ";

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  function automatic logic [7:0] dig_asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic is_dig(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Tick generation
  logic [CNT_W-1:0] cnt_q;
  logic             tick_s;

  // Per-channel state
  logic [LIM_W-1:0]  hi_q [NUM_CH];
  logic [LIM_W-1:0]  lo_q [NUM_CH];
  logic [NUM_CH-1:0] man_q;
  logic [NUM_CH-1:0] act_q;
  logic [NUM_CH-1:0] act_eval_s;
  logic              alarm_q;
  logic              any_out_s;
  logic [VW-1:0]     v_x;
  logic [VW-1:0]     hi_x;
  logic [VW-1:0]     lo_x;

  // Command path
  state_e           state_q, state_d;
  logic             ready_q, ack_q, err_q, ack_d, err_d;
  logic [7:0]       code_q, ch_q, d1_q, d0_q;
  logic             ch_ok_s, dig_ok_s, ok_s, apply_s;
  logic [PAGE_W-1:0] ch_sel_s;
  logic [LIM_W-1:0] val_s;

  // Display pipeline
  logic [PAGE_W-1:0] page_q, cap_ch_q;
  logic [DATA_W-1:0] cap_val_q;
  logic              cap_vld_q, lcd_en_q;
  logic [127:0]      row1_q, row2_q, row1_s, row2_s;
  logic [3:0]        hund_s, tens_s, unit_s;
  logic [LIM_W-1:0]  lo_v_s, hi_v_s;

  assign tick_s = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Free-running tick counter, wraps at TICK_DIV-1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Threshold evaluation with hysteresis, plus out-of-band detection for alarm
  always_comb begin
    act_eval_s = act_q;
    any_out_s  = 1'b0;
    v_x        = {VW{1'b0}};
    hi_x       = {VW{1'b0}};
    lo_x       = {VW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      v_x  = VW'(sensor_data_i[i*DATA_W +: DATA_W]);
      hi_x = VW'(hi_q[i]);
      lo_x = VW'(lo_q[i]);
      if ((v_x > hi_x) || (v_x < lo_x)) begin
        any_out_s = 1'b1;
      end else begin
        any_out_s = any_out_s;
      end
      if (man_q[i]) begin
        act_eval_s[i] = act_q[i];
      end else if (CH_POL[i]) begin
        if (v_x > hi_x) begin
          act_eval_s[i] = 1'b1;
        end else if ((v_x + VW'(HYST)) <= hi_x) begin
          act_eval_s[i] = 1'b0;
        end else begin
          act_eval_s[i] = act_q[i];
        end
      end else begin
        if (v_x < lo_x) begin
          act_eval_s[i] = 1'b1;
        end else if (v_x >= (lo_x + VW'(HYST))) begin
          act_eval_s[i] = 1'b0;
        end else begin
          act_eval_s[i] = act_q[i];
        end
      end
    end
  end

  // Decode and validate the latched command against the current limits
  always_comb begin
    ok_s     = 1'b0;
    ch_ok_s  = is_dig(ch_q) && (int'(ch_q[3:0]) < NUM_CH);
    dig_ok_s = is_dig(d1_q) && is_dig(d0_q);
    val_s    = LIM_W'(d1_q[3:0]) * 7'd10 + LIM_W'(d0_q[3:0]);
    if (ch_ok_s) begin
      ch_sel_s = PAGE_W'(ch_q[3:0]);
    end else begin
      ch_sel_s = {PAGE_W{1'b0}};
    end
    case (code_q)
      8'h48:        ok_s = ch_ok_s && dig_ok_s && (val_s >= lo_q[ch_sel_s]);  // 'H'
      8'h4C:        ok_s = ch_ok_s && dig_ok_s && (val_s <= hi_q[ch_sel_s]);  // 'L'
      8'h4D:        ok_s = ch_ok_s && ((d0_q == 8'h30) || (d0_q == 8'h31));   // 'M'
      8'h41, 8'h43: ok_s = ch_ok_s;                                           // 'A','C'
      default:      ok_s = 1'b0;
    endcase
  end

  // Command FSM next state and ack/err pulse generation
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        state_d = S_APPLY;
        ack_d   = ok_s;
        err_d   = ~ok_s;
      end
      S_APPLY: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command FSM state register and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Latch all command fields when the command is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= 8'h00;
      ch_q   <= 8'h00;
      d1_q   <= 8'h00;
      d0_q   <= 8'h00;
    end else if ((state_q == S_IDLE) && cmd_valid_i) begin
      code_q <= cmd_code_i;
      ch_q   <= cmd_ch_i;
      d1_q   <= cmd_d1_i;
      d0_q   <= cmd_d0_i;
    end
  end

  // ack_q is high exactly in APPLY cycles of accepted commands
  assign apply_s = (state_q == S_APPLY) && ack_q;

  // Limits, modes and actuators; a command write overrides the tick result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        hi_q[i] <= LIM_W'(HI_RST);
        lo_q[i] <= LIM_W'(LO_RST);
      end
      man_q <= {NUM_CH{1'b0}};
      act_q <= {NUM_CH{1'b0}};
    end else begin
      if (tick_s) begin
        act_q <= act_eval_s;
      end
      if (apply_s) begin
        case (code_q)
          8'h48: hi_q[ch_sel_s] <= val_s;
          8'h4C: lo_q[ch_sel_s] <= val_s;
          8'h4D: begin
            man_q[ch_sel_s] <= 1'b1;
            act_q[ch_sel_s] <= d0_q[0];
          end
          8'h41: man_q[ch_sel_s] <= 1'b0;
          default: begin
          end
        endcase
      end
    end
  end

`ifdef CSC_ALARM_LATCH_EN
  // Sticky alarm: set on an out-of-band tick, cleared by 'C'; set wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= (tick_s & any_out_s) |
                 (alarm_q & ~(apply_s && (code_q == 8'h43)));
    end
  end
`else
  // Alarm recomputed from the band check on every tick
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alarm_q <= 1'b0;
    end else if (tick_s) begin
      alarm_q <= any_out_s;
    end
  end
`endif

  // Decimal conversion of the captured value and status row formatting
  always_comb begin
    hund_s = 4'(cap_val_q / DATA_W'(100));
    tens_s = 4'((cap_val_q / DATA_W'(10)) % DATA_W'(10));
    unit_s = 4'(cap_val_q % DATA_W'(10));
    lo_v_s = lo_q[cap_ch_q];
    hi_v_s = hi_q[cap_ch_q];
    row1_s = {"CH", dig_asc(4'(cap_ch_q)), " VAL ",
              dig_asc(hund_s), dig_asc(tens_s), dig_asc(unit_s), " ",
              (act_q[cap_ch_q] ? "ON  " : "OFF ")};
    row2_s = {"LO ", dig_asc(4'(lo_v_s / 7'd10)), dig_asc(4'(lo_v_s % 7'd10)),
              " HI ", dig_asc(4'(hi_v_s / 7'd10)), dig_asc(4'(hi_v_s % 7'd10)),
              " ", (man_q[cap_ch_q] ? 8'h4D : 8'h41), "   "};
  end

  // Display pipeline: capture on tick, format next cycle, rows change with lcd_en
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      page_q    <= {PAGE_W{1'b0}};
      cap_ch_q  <= {PAGE_W{1'b0}};
      cap_val_q <= {DATA_W{1'b0}};
      cap_vld_q <= 1'b0;
      lcd_en_q  <= 1'b0;
      row1_q    <= ROW1_RST;
      row2_q    <= ROW2_RST;
    end else begin
      cap_vld_q <= tick_s;
      lcd_en_q  <= cap_vld_q;
      if (tick_s) begin
        cap_ch_q  <= page_q;
        cap_val_q <= sensor_data_i[page_q*DATA_W +: DATA_W];
        if (page_q == PAGE_W'(NUM_CH - 1)) begin
          page_q <= {PAGE_W{1'b0}};
        end else begin
          page_q <= page_q + PAGE_W'(1);
        end
      end
      if (cap_vld_q) begin
        row1_q <= row1_s;
        row2_q <= row2_s;
      end
    end
  end

  assign cmd_ready_o = ready_q;
  assign cmd_ack_o   = ack_q;
  assign cmd_err_o   = err_q;
  assign act_on_o    = act_q;
  assign alarm_o     = alarm_q;
  assign lcd_en_o    = lcd_en_q;
  assign lcd_row1_o  = row1_q;
  assign lcd_row2_o  = row2_q;

endmodule

// File: tb/tb_multi_ch_climate_ctrl.sv
// Testbench for multi_ch_climate_ctrl (NUM_CH=2, TICK_DIV=16, HYST=2).
// A cycle-level behavioural model computes expected outputs from the
// controller rules; directed scenarios are followed by randomized traffic.
module tb_multi_ch_climate_ctrl;

  localparam int          NCH  = 2;
  localparam int          TDIV = 16;
  localparam int          HYS  = 2;
  localparam logic [1:0]  POL  = 2'b01;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  sensor;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_code, cmd_ch, cmd_d1, cmd_d0;
  logic         cmd_ack, cmd_err;
  logic [1:0]   act_on;
  logic         alarm;
  logic         lcd_en;
  logic [127:0] lcd_row1, lcd_row2;

  always #5 clk = ~clk;

  multi_ch_climate_ctrl #(
    .NUM_CH(NCH), .DATA_W(8), .TICK_DIV(TDIV), .HYST(HYS),
    .CH_POL(POL), .HI_RST(18), .LO_RST(10)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sensor_data_i(sensor),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_code_i(cmd_code), .cmd_ch_i(cmd_ch), .cmd_d1_i(cmd_d1), .cmd_d0_i(cmd_d0),
    .cmd_ack_o(cmd_ack), .cmd_err_o(cmd_err), .act_on_o(act_on), .alarm_o(alarm),
    .lcd_en_o(lcd_en), .lcd_row1_o(lcd_row1), .lcd_row2_o(lcd_row2)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [127:0] s2row(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int           m_hi[NCH], m_lo[NCH];
  bit           m_man[NCH], m_act[NCH];
  bit           m_alarm;
  int           m_tcnt, m_page;
  bit           m_cap_vld;
  int           m_cap_ch, m_cap_val;
  bit           m_lcd_en;
  logic [127:0] m_row1, m_row2;
  bit           m_busy, m_ok, m_ack, m_err, m_d0bit;
  int           m_age, m_ch, m_val;
  logic [7:0]   m_code;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_hi[c] = 18; m_lo[c] = 10; m_man[c] = 0; m_act[c] = 0;
    end
    m_alarm = 0; m_tcnt = 0; m_page = 0; m_cap_vld = 0; m_cap_ch = 0; m_cap_val = 0;
    m_lcd_en = 0; m_busy = 0; m_ok = 0; m_ack = 0; m_err = 0; m_age = 0;
    m_row1 = s2row("  Cold Storage  ");
    m_row2 = s2row("     Welcome    ");
  endtask

  function automatic bit is_digit(input logic [7:0] c);
    return (c >= "0") && (c <= "9");
  endfunction

  // Advance the model across one clock edge using the inputs applied now
  task automatic model_step();
    int v[NCH];
    int hi_n[NCH], lo_n[NCH];
    bit man_n[NCH], act_n[NCH];
    bit tick, any_out, clr, alarm_n, chv;
    v[0] = int'(sensor[7:0]);
    v[1] = int'(sensor[15:8]);
    if (rst) begin
      model_reset();
      return;
    end
    hi_n = m_hi; lo_n = m_lo; man_n = m_man; act_n = m_act;
    alarm_n = m_alarm; clr = 0; any_out = 0;
    tick = (m_tcnt == TDIV - 1);
    for (int c = 0; c < NCH; c++) begin
      if (v[c] > m_hi[c] || v[c] < m_lo[c]) any_out = 1;
      if (tick && !m_man[c]) begin
        if (POL[c]) begin
          if (v[c] > m_hi[c]) act_n[c] = 1;
          else if (v[c] + HYS <= m_hi[c]) act_n[c] = 0;
        end else begin
          if (v[c] < m_lo[c]) act_n[c] = 1;
          else if (v[c] >= m_lo[c] + HYS) act_n[c] = 0;
        end
      end
    end
    // rows are formatted one cycle after capture and appear with lcd_en
    m_lcd_en = m_cap_vld;
    if (m_cap_vld) begin
      m_row1 = s2row($sformatf("CH%0d VAL %03d %s", m_cap_ch, m_cap_val,
                               m_act[m_cap_ch] ? "ON  " : "OFF "));
      m_row2 = s2row($sformatf("LO %02d HI %02d %s   ", m_lo[m_cap_ch], m_hi[m_cap_ch],
                               m_man[m_cap_ch] ? "M" : "A"));
    end
    m_cap_vld = tick;
    if (tick) begin
      m_cap_ch  = m_page;
      m_cap_val = v[m_page];
      m_page    = (m_page + 1) % NCH;
    end
    m_tcnt = tick ? 0 : m_tcnt + 1;
    // command handling: check cycle then apply cycle after acceptance
    m_ack = 0; m_err = 0;
    if (m_busy) begin
      if (m_age == 0) begin
        m_ack = m_ok; m_err = !m_ok; m_age = 1;
      end else begin
        if (m_ok) begin
          case (m_code)
            "H": hi_n[m_ch] = m_val;
            "L": lo_n[m_ch] = m_val;
            "M": begin man_n[m_ch] = 1; act_n[m_ch] = m_d0bit; end
            "A": man_n[m_ch] = 0;
            "C": clr = 1;
            default: ;
          endcase
        end
        m_busy = 0;
      end
    end else if (cmd_valid) begin
      m_busy  = 1; m_age = 0; m_code = cmd_code;
      m_ch    = int'(cmd_ch) - 48;
      m_val   = (int'(cmd_d1) - 48) * 10 + (int'(cmd_d0) - 48);
      m_d0bit = (cmd_d0 == "1");
      chv     = is_digit(cmd_ch) && (m_ch < NCH);
      case (cmd_code)
        "H": m_ok = chv && is_digit(cmd_d1) && is_digit(cmd_d0) && (m_val >= m_lo[m_ch]);
        "L": m_ok = chv && is_digit(cmd_d1) && is_digit(cmd_d0) && (m_val <= m_hi[m_ch]);
        "M": m_ok = chv && (cmd_d0 == "0" || cmd_d0 == "1");
        "A", "C": m_ok = chv;
        default: m_ok = 0;
      endcase
    end
`ifdef CSC_ALARM_LATCH_EN
    alarm_n = (tick && any_out) || (m_alarm && !clr);
`else
    if (tick) alarm_n = any_out;
`endif
    m_hi = hi_n; m_lo = lo_n; m_man = man_n; m_act = act_n; m_alarm = alarm_n;
  endtask

  task automatic check_all();
    chk_val("act_on", act_on, {m_act[1], m_act[0]});
    chk_val("alarm", alarm, m_alarm);
    chk_val("cmd_ready", cmd_ready, !m_busy);
    chk_val("cmd_ack", cmd_ack, m_ack);
    chk_val("cmd_err", cmd_err, m_err);
    chk_val("lcd_en", lcd_en, m_lcd_en);
    chk_val("row1", lcd_row1, m_row1);
    chk_val("row2", lcd_row2, m_row2);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_sens(input int a, input int b);
    sensor = {8'(b), 8'(a)};
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] ch,
                          input logic [7:0] d1, input logic [7:0] d0);
    cmd_code = c; cmd_ch = ch; cmd_d1 = d1; cmd_d0 = d0;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    run(3);
  endtask

  logic [7:0] codes [6] = '{"H", "L", "M", "A", "C", "Z"};
  bit found;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; cmd_ch = 8'h00;
    cmd_d1 = 8'h00; cmd_d0 = 8'h00;
    set_sens(15, 15);
    run(3);
    rst = 1'b0;
    run(20);

    // cooler hysteresis on channel 0
    set_sens(20, 15); run(16);
    set_sens(17, 15); run(16);
    set_sens(16, 15); run(16);

    // raise HI, then 30 turns on and 20 turns off again
    send_cmd("H", "0", "2", "5");
    set_sens(30, 15); run(16);
    set_sens(20, 15); run(32);

    // rejected commands
    send_cmd("H", "0", "x", "5");
    send_cmd("L", "1", "9", "9");
    send_cmd("H", "2", "1", "5");
    send_cmd("Z", "0", "1", "5");

    // reset while a command is in flight
    cmd_code = "H"; cmd_ch = "1"; cmd_d1 = "1"; cmd_d0 = "5";
    cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    set_sens(7, 15);
    rst = 1'b1; run(2); rst = 1'b0;

    // first status page after reset shows channel 0 at 7
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (lcd_en === 1'b1 && lcd_row1[127:104] === "CH0") found = 1'b1;
    end
    chk_val("page0_seen", found, 1'b1);
    chk_val("page0_row1", lcd_row1, s2row("CH0 VAL 007 OFF "));
    chk_val("page0_row2", lcd_row2, s2row("LO 10 HI 18 A   "));
    run(20);

    // humidifier alarm on channel 1, then recovery, then clear
    set_sens(15, 5);  run(20);
    set_sens(15, 12); run(20);
    send_cmd("C", "0", "0", "0");
    run(20);

    // command applied on the same cycle as a tick
    set_sens(17, 15);
    for (int i = 0; i < 20 && m_tcnt != 13; i++) step();
    send_cmd("H", "0", "1", "2");
    run(36);

    // manual override and return to auto
    send_cmd("M", "1", "0", "1");
    run(40);
    send_cmd("A", "1", "0", "0");
    run(20);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        sensor[c*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 30));
      end
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_code  = codes[$urandom_range(0, 5)];
      cmd_ch    = 8'(48 + $urandom_range(0, 3));
      cmd_d1    = ($urandom_range(0, 7) == 0) ? 8'h78 : 8'(48 + $urandom_range(0, 2));
      cmd_d0    = ($urandom_range(0, 7) == 0) ? 8'h78 : 8'(48 + $urandom_range(0, 9));
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
